// File: rtl/lss_pkg.sv
// Shared types and default timing constants for the line scan scheduler.
package lss_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DELAY   = 2'd1,
    S_PULSE   = 2'd2,
    S_READOUT = 2'd3
  } lss_state_e;

  typedef enum logic {
    RR_MCU = 1'b0,
    RR_MOD = 1'b1
  } lss_src_e;

  localparam int LSS_DELAY_CYCLES   = 22;
  localparam int LSS_PULSE_CYCLES   = 13;
  localparam int LSS_READOUT_CYCLES = 256;
  localparam int LSS_CNT_W          = 16;

  function automatic int lss_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lss_req_sync.sv
// Request conditioner: optional 2-flop synchronizer followed by a rising-edge detector.
module lss_req_sync #(
  parameter bit BYPASS = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  output logic edge_o
);

  logic req_s;
  logic prev_q;

  generate
    if (BYPASS) begin : g_bypass
      assign req_s = req_i;
    end else begin : g_sync
      logic s1_q;
      logic s2_q;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          s1_q <= 1'b0;
          s2_q <= 1'b0;
        end else begin
          s1_q <= req_i;
          s2_q <= s1_q;
        end
      end
      assign req_s = s2_q;
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) prev_q <= 1'b0;
    else       prev_q <= req_s;
  end

  assign edge_o = req_s & ~prev_q;

endmodule

// File: rtl/line_scan_scheduler.sv
// Sequences delay/pulse/readout for one diode line and round-robins MCU and module requests.
// Build option LSS_AUTO_TRIGGER_EN adds a periodic request into the module path.
module line_scan_scheduler
  import lss_pkg::*;
#(
  parameter int DELAY_CYCLES   = LSS_DELAY_CYCLES,
  parameter int PULSE_CYCLES   = LSS_PULSE_CYCLES,
  parameter int READOUT_CYCLES = LSS_READOUT_CYCLES,
  parameter int CNT_W          = LSS_CNT_W
) (
  input  logic             clk_10MHz_i,
  input  logic             reset,
  input  logic             mcu_req,
  input  logic             mod_req,
  input  logic             abort,
  input  logic             clr_overrun,
  input  logic             auto_en,
  input  logic [CNT_W-1:0] auto_period,
  output logic             line_start,
  output logic             grant_mcu,
  output logic             grant_mod,
  output logic             diode_pulse,
  output logic             readout_active,
  output logic             busy,
  output logic             overrun,
  output logic [CNT_W-1:0] line_count
);

  localparam int PH_MAX = lss_max3(DELAY_CYCLES, PULSE_CYCLES, READOUT_CYCLES);
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam lss_state_e FIRST_STATE = (DELAY_CYCLES == 0) ? S_PULSE : S_DELAY;
  localparam logic [PH_W-1:0] DELAY_LAST = PH_W'(DELAY_CYCLES - 1);
  localparam logic [PH_W-1:0] PULSE_LAST = PH_W'(PULSE_CYCLES - 1);
  localparam logic [PH_W-1:0] READ_LAST  = PH_W'(READOUT_CYCLES - 1);

  lss_state_e       state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  lss_src_e         rr_q;
  logic             pend_mcu_q, pend_mcu_d;
  logic             pend_mod_q, pend_mod_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] line_count_q;
  logic             line_start_q, grant_mcu_q, grant_mod_q;
  logic             diode_pulse_q, readout_q, busy_q;
  logic             mcu_edge, mod_edge, auto_tick, mod_any;
  logic             rd_last, can_grant, gnt_mcu, gnt_mod, cnt_inc, ovr_set;

  lss_req_sync #(.BYPASS(1'b0)) u_mcu_sync (
    .clk_i (clk_10MHz_i),
    .rst_i (reset),
    .req_i (mcu_req),
    .edge_o(mcu_edge)
  );

  lss_req_sync #(.BYPASS(1'b1)) u_mod_sync (
    .clk_i (clk_10MHz_i),
    .rst_i (reset),
    .req_i (mod_req),
    .edge_o(mod_edge)
  );

`ifdef LSS_AUTO_TRIGGER_EN
  logic [CNT_W-1:0] auto_cnt_q, auto_per_q, auto_per_eff;
  logic             auto_on;

  // A new period value is only picked up when the count restarts from zero.
  assign auto_on      = auto_en && (auto_period != '0);
  assign auto_per_eff = (auto_cnt_q == '0) ? auto_period : auto_per_q;
  assign auto_tick    = auto_on && (auto_cnt_q == auto_per_eff - 1'b1);

  always_ff @(posedge clk_10MHz_i or posedge reset) begin
    if (reset) begin
      auto_cnt_q <= '0;
      auto_per_q <= '0;
    end else if (!auto_on) begin
      auto_cnt_q <= '0;
      auto_per_q <= auto_period;
    end else begin
      auto_per_q <= auto_per_eff;
      auto_cnt_q <= auto_tick ? '0 : auto_cnt_q + 1'b1;
    end
  end
`else
  logic auto_unused;
  assign auto_unused = auto_en ^ (^auto_period);
  assign auto_tick   = 1'b0;
`endif

  assign mod_any = mod_edge | auto_tick;

  always_comb begin
    rd_last   = (state_q == S_READOUT) && (ph_q == READ_LAST);
    can_grant = (state_q == S_IDLE) || (rd_last && !abort);
    // With both pending, the source not granted last time wins.
    gnt_mcu   = can_grant && pend_mcu_q && (!pend_mod_q || rr_q == RR_MOD);
    gnt_mod   = can_grant && pend_mod_q && (!pend_mcu_q || rr_q == RR_MCU);

    pend_mcu_d = (pend_mcu_q & ~gnt_mcu) | mcu_edge;
    pend_mod_d = (pend_mod_q & ~gnt_mod) | mod_any;
    ovr_set    = (mcu_edge & pend_mcu_q & ~gnt_mcu) | (mod_any & pend_mod_q & ~gnt_mod);
    overrun_d  = ovr_set ? 1'b1 : (clr_overrun ? 1'b0 : overrun_q);

    state_d = state_q;
    ph_d    = ph_q + 1'b1;
    cnt_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        ph_d = '0;
        if (gnt_mcu || gnt_mod) state_d = FIRST_STATE;
      end
      S_DELAY: begin
        if (abort) begin
          state_d = S_IDLE;
          ph_d    = '0;
        end else if (ph_q == DELAY_LAST) begin
          state_d = S_PULSE;
          ph_d    = '0;
        end
      end
      S_PULSE: begin
        if (abort) begin
          state_d = S_IDLE;
          ph_d    = '0;
        end else if (ph_q == PULSE_LAST) begin
          state_d = S_READOUT;
          ph_d    = '0;
        end
      end
      S_READOUT: begin
        if (abort) begin
          state_d = S_IDLE;
          ph_d    = '0;
        end else if (rd_last) begin
          cnt_inc = 1'b1;
          ph_d    = '0;
          state_d = (gnt_mcu || gnt_mod) ? FIRST_STATE : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        ph_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk_10MHz_i or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ph_q          <= '0;
      rr_q          <= RR_MCU;
      pend_mcu_q    <= 1'b0;
      pend_mod_q    <= 1'b0;
      overrun_q     <= 1'b0;
      line_count_q  <= '0;
      line_start_q  <= 1'b0;
      grant_mcu_q   <= 1'b0;
      grant_mod_q   <= 1'b0;
      diode_pulse_q <= 1'b0;
      readout_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ph_q          <= ph_d;
      pend_mcu_q    <= pend_mcu_d;
      pend_mod_q    <= pend_mod_d;
      overrun_q     <= overrun_d;
      line_start_q  <= gnt_mcu | gnt_mod;
      grant_mcu_q   <= gnt_mcu;
      grant_mod_q   <= gnt_mod;
      diode_pulse_q <= (state_d == S_PULSE);
      readout_q     <= (state_d == S_READOUT);
      busy_q        <= (state_d != S_IDLE);
      if (cnt_inc) line_count_q <= line_count_q + 1'b1;
      if (gnt_mcu)      rr_q <= RR_MCU;
      else if (gnt_mod) rr_q <= RR_MOD;
    end
  end

  assign line_start     = line_start_q;
  assign grant_mcu      = grant_mcu_q;
  assign grant_mod      = grant_mod_q;
  assign diode_pulse    = diode_pulse_q;
  assign readout_active = readout_q;
  assign busy           = busy_q;
  assign overrun        = overrun_q;
  assign line_count     = line_count_q;

endmodule
